// File: rtl/module_keypad_scan.sv
// 4x4 active-low matrix keypad scanner with press/release debounce.
// Emits one registered tecla pulse per accepted press plus its key code.
module module_keypad_scan #(
   parameter int SCAN_CYCLES     = 1000,
   parameter int DEBOUNCE_CYCLES = 100000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] row,
   output logic [3:0] col,
   output logic       tecla,
   output logic [3:0] key
);

   localparam int SW = (SCAN_CYCLES > 1) ? $clog2(SCAN_CYCLES) : 1;
   localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [SW-1:0] SC_LAST = SW'(SCAN_CYCLES - 1);
   localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);

   typedef enum logic [1:0] {
      SCAN,
      DEB_PRESS,
      PRESS,
      DEB_REL
   } state_t;

   state_t        state_q, state_d;
   logic [3:0]    sync1_q, row_s;
   logic [SW-1:0] scan_q, scan_d;
   logic [DW-1:0] deb_q, deb_d;
   logic [1:0]    ci_q, ci_d;
   logic [1:0]    ri_q, ri_d;
   logic [3:0]    pat_q, pat_d;
   logic [3:0]    key_q, key_d;
   logic          tecla_q, tecla_d;

   function automatic logic [1:0] low_row(input logic [3:0] r);
      if (!r[0])      return 2'd0;
      else if (!r[1]) return 2'd1;
      else if (!r[2]) return 2'd2;
      else            return 2'd3;
   endfunction

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1_q <= 4'hF;
         row_s   <= 4'hF;
      end else begin
         sync1_q <= row;
         row_s   <= sync1_q;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= SCAN;
         scan_q  <= '0;
         deb_q   <= '0;
         ci_q    <= 2'd0;
         ri_q    <= 2'd0;
         pat_q   <= 4'hF;
         key_q   <= 4'h0;
         tecla_q <= 1'b0;
      end else begin
         state_q <= state_d;
         scan_q  <= scan_d;
         deb_q   <= deb_d;
         ci_q    <= ci_d;
         ri_q    <= ri_d;
         pat_q   <= pat_d;
         key_q   <= key_d;
         tecla_q <= tecla_d;
      end
   end

   always_comb begin
      state_d = state_q;
      scan_d  = scan_q;
      deb_d   = deb_q;
      ci_d    = ci_q;
      ri_d    = ri_q;
      pat_d   = pat_q;
      key_d   = key_q;
      tecla_d = 1'b0;
      unique case (state_q)
         SCAN: begin
            // Sample late in the column slot so the synchronizer has settled
            if (scan_q == SC_LAST) begin
               scan_d = '0;
               if (row_s != 4'hF) begin
                  pat_d   = row_s;
                  ri_d    = low_row(row_s);
                  deb_d   = '0;
                  state_d = DEB_PRESS;
               end else begin
                  ci_d = ci_q + 2'd1;
               end
            end else begin
               scan_d = scan_q + 1'b1;
            end
         end
         DEB_PRESS: begin
            if (row_s != pat_q) begin
               state_d = SCAN;
               ci_d    = ci_q + 2'd1;
               scan_d  = '0;
            end else if (deb_q == DB_LAST) begin
               state_d = PRESS;
               tecla_d = 1'b1;
               key_d   = {ri_q, ci_q};
            end else begin
               deb_d = deb_q + 1'b1;
            end
         end
         PRESS: begin
            state_d = DEB_REL;
            deb_d   = '0;
         end
         DEB_REL: begin
            if (row_s != 4'hF) begin
               deb_d = '0;
            end else if (deb_q == DB_LAST) begin
               state_d = SCAN;
               ci_d    = ci_q + 2'd1;
               scan_d  = '0;
            end else begin
               deb_d = deb_q + 1'b1;
            end
         end
         default: state_d = SCAN;
      endcase
   end

   assign col   = ~(4'b0001 << ci_q);
   assign tecla = tecla_q;
   assign key   = key_q;

endmodule

// File: tb/tb_module_keypad_scan.sv
// Directed bench for module_keypad_scan with a 4x4 switch-matrix model
// (SCAN_CYCLES=4, DEBOUNCE_CYCLES=8); cycle numbers count from reset release.
module tb_module_keypad_scan;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [3:0]  row;
   logic [3:0]  col;
   logic        tecla;
   logic [3:0]  key;
   logic [15:0] mask = 16'h0;

   int cyc = 0;
   int n_chk = 0;
   int n_err = 0;
   int tecla_cnt = 0;
   int tecla_cyc = -1;

   module_keypad_scan #(
      .SCAN_CYCLES    (4),
      .DEBOUNCE_CYCLES(8)
   ) dut (
      .clk  (clk),
      .rst  (rst),
      .row  (row),
      .col  (col),
      .tecla(tecla),
      .key  (key)
   );

   always #5 clk = ~clk;

   // mask bit r*4+c closed pulls row r low while column c is driven
   always_comb begin
      row = 4'hF;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            if (mask[r*4+c] && !col[c]) row[r] = 1'b0;
   end

   always @(posedge clk or posedge rst)
      if (rst) cyc <= 0;
      else     cyc <= cyc + 1;

   always @(negedge clk)
      if (rst) begin
         tecla_cnt = 0;
         tecla_cyc = -1;
      end else if (tecla) begin
         tecla_cnt = tecla_cnt + 1;
         tecla_cyc = cyc;
      end

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                  tag, got, exp, cyc);
      end
   endtask

   task automatic wait_cyc(input int k);
      while (cyc < k) @(negedge clk);
   endtask

   task automatic do_reset(input logic [15:0] m);
      @(negedge clk);
      rst  = 1'b1;
      mask = m;
      #1;
      chk("rst_col", {28'h0, col}, 32'hE);
      chk("rst_tecla", {31'h0, tecla}, 32'h0);
      chk("rst_key", {28'h0, key}, 32'h0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [3:0] one;
      one = 4'b0001;

      // idle column walk
      do_reset(16'h0);
      for (int k = 0; k < 20; k++) begin
         wait_cyc(k);
         chk("idle_col", {28'h0, col}, {28'h0, ~(one << ((k / 4) % 4))});
         chk("idle_tecla", {31'h0, tecla}, 32'h0);
      end

      // row 2 / column 2 press, sample at 11, tecla at 20, release mid-48
      do_reset(16'h1 << 10);
      wait_cyc(19);
      chk("p22_pre", {31'h0, tecla}, 32'h0);
      wait_cyc(20);
      chk("p22_tecla", {31'h0, tecla}, 32'h1);
      chk("p22_key", {28'h0, key}, 32'hA);
      chk("p22_col", {28'h0, col}, 32'hB);
      wait_cyc(21);
      chk("p22_one", {31'h0, tecla}, 32'h0);
      wait_cyc(48);
      mask = 16'h0;
      wait_cyc(57);
      chk("p22_hold", {28'h0, col}, 32'hB);
      wait_cyc(58);
      chk("p22_next", {28'h0, col}, 32'h7);
      wait_cyc(62);
      chk("p22_wrap", {28'h0, col}, 32'hE);
      wait_cyc(70);
      chk("p22_cnt", tecla_cnt, 32'd1);
      chk("p22_keep", {28'h0, key}, 32'hA);

      // bounce in press debounce, retry on column 0 at 23, tecla at 32
      do_reset(16'h1);
      wait_cyc(5);
      mask = 16'h0;
      wait_cyc(6);
      mask = 16'h1;
      wait_cyc(7);
      chk("bnc_frz", {28'h0, col}, 32'hE);
      wait_cyc(8);
      chk("bnc_adv", {28'h0, col}, 32'hD);
      wait_cyc(31);
      chk("bnc_none", tecla_cnt, 32'd0);
      wait_cyc(32);
      chk("bnc_tecla", {31'h0, tecla}, 32'h1);
      chk("bnc_key", {28'h0, key}, 32'h0);
      wait_cyc(45);
      chk("bnc_cnt", tecla_cnt, 32'd1);

      // rows 1 and 3 on column 1: row 1 wins, tecla at 16
      do_reset((16'h1 << 5) | (16'h1 << 13));
      wait_cyc(16);
      chk("dual_tecla", {31'h0, tecla}, 32'h1);
      chk("dual_key", {28'h0, key}, 32'h5);
      chk("dual_col", {28'h0, col}, 32'hD);
      wait_cyc(30);
      mask = 16'h0;
      wait_cyc(50);
      chk("dual_cnt", tecla_cnt, 32'd1);

      // long hold on (3,3), release bouncing twice, last rise at 518
      do_reset(16'h1 << 15);
      wait_cyc(24);
      chk("long_tecla", {31'h0, tecla}, 32'h1);
      chk("long_key", {28'h0, key}, 32'hF);
      wait_cyc(508);
      mask = 16'h0;
      wait_cyc(510);
      mask = 16'h1 << 15;
      wait_cyc(512);
      mask = 16'h0;
      wait_cyc(514);
      mask = 16'h1 << 15;
      wait_cyc(516);
      mask = 16'h0;
      wait_cyc(525);
      chk("long_hold", {28'h0, col}, 32'h7);
      wait_cyc(526);
      chk("long_scan", {28'h0, col}, 32'hE);
      wait_cyc(530);
      chk("long_cnt", tecla_cnt, 32'd1);
      chk("long_cyc", tecla_cyc, 32'd24);

      // async reset in the middle of a second press debounce
      do_reset(16'h1 << 9);
      wait_cyc(16);
      chk("ar_tecla", {31'h0, tecla}, 32'h1);
      chk("ar_key", {28'h0, key}, 32'h9);
      wait_cyc(20);
      mask = 16'h0;
      wait_cyc(30);
      chk("ar_rescan", {28'h0, col}, 32'hB);
      wait_cyc(31);
      mask = 16'h1 << 9;
      wait_cyc(49);
      chk("ar_frz", {28'h0, col}, 32'hD);
      chk("ar_nopulse", tecla_cnt, 32'd1);
      #2;
      rst = 1'b1;
      #1;
      chk("ar_col", {28'h0, col}, 32'hE);
      chk("ar_tecla0", {31'h0, tecla}, 32'h0);
      chk("ar_key0", {28'h0, key}, 32'h0);
      @(negedge clk);
      mask = 16'h0;
      @(negedge clk);
      rst = 1'b0;
      wait_cyc(40);
      chk("ar_after", tecla_cnt, 32'd0);
      chk("ar_keyq", {28'h0, key}, 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
